// File: rtl/spi_sched_pkg.sv
// Shared types for the SPI transfer scheduler: FSM states, response error
// codes and the default transfer word width.
package spi_sched_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_TIMEOUT  = 2'b01,
    ERR_MISMATCH = 2'b10
  } rsp_err_e;

endpackage

// File: rtl/spi_xfer_scheduler_rr_arbiter.sv
// Combinational round-robin picker: returns the first set request bit at or
// after ptr_i, wrapping past the top. The pointer itself lives in the caller.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         valid_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [$clog2(N)-1:0] grant_o,
  output logic                 any_o
);

  localparam int IW = $clog2(N);

  logic [IW:0] idx;

  // Scan from the farthest candidate back to ptr_i so the nearest set bit wins.
  always_comb begin
    grant_o = '0;
    any_o   = |valid_i;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_i} + (IW + 1)'(k);
      if (idx >= (IW + 1)'(N)) begin
        idx = idx - (IW + 1)'(N);
      end
      if (valid_i[idx[IW-1:0]]) begin
        grant_o = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/spi_xfer_scheduler.sv
// Shares one A-to-B SPI link among NUM_REQ requesters: round-robin grant,
// one 32-bit transfer at a time, response returned to the granted requester
// with an increment-contract check and a per-transfer timeout.
//
// Handshakes: a requester raises req_valid[i] with req_data slice i stable and
// holds both until it sees the one-cycle req_ready[i] pulse; the matching
// response is the one-cycle rsp_valid[i] pulse, with rsp_data/rsp_err valid
// only in that cycle. On the link side link_start is a one-cycle launch pulse,
// link_wdata stays stable until the response is returned, and link_rdata is
// only sampled in a cycle where link_done is high while a transfer is open.
module spi_xfer_scheduler
  import spi_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYC = 4096,
  parameter bit CHECK_INC   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [1:0]                rsp_err,
  output logic                      link_start,
  output logic [DATA_W-1:0]         link_wdata,
  input  logic                      link_done,
  input  logic [DATA_W-1:0]         link_rdata,
  output logic                      busy,
  output state_e                    dbg_state
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  // The counter value that includes the current WAIT cycle reaches this on
  // the last WAIT cycle, so rsp_valid lands TIMEOUT_CYC cycles after link_start.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [IW-1:0] LAST_REQ = IW'(NUM_REQ - 1);

  state_e              state_q;
  logic [IW-1:0]       ptr_q;
  logic [IW-1:0]       gnt_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic [NUM_REQ-1:0]  req_ready_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [1:0]          rsp_err_q;
  logic                link_start_q;
  logic [DATA_W-1:0]   link_wdata_q;
  logic                busy_q;

  logic [IW-1:0]       arb_idx;
  logic                arb_any;
  logic [NUM_REQ-1:0]  gnt_oh;
  logic [DATA_W-1:0]   wdata_inc;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_idx),
    .any_o   (arb_any)
  );

  assign cnt_d     = cnt_q + CW'(1);
  assign gnt_oh    = NUM_REQ'(1) << gnt_q;
  assign wdata_inc = link_wdata_q + DATA_W'(1);

  // Scheduler FSM; every output is a register updated on the state's exit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gnt_q        <= '0;
      cnt_q        <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= ERR_OK;
      link_start_q <= 1'b0;
      link_wdata_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      link_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            gnt_q   <= arb_idx;
            busy_q  <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (req_valid[gnt_q]) begin
            req_ready_q  <= gnt_oh;
            link_wdata_q <= req_data[gnt_q*DATA_W +: DATA_W];
            state_q      <= START;
          end else begin
            // Request withdrawn before accept: pointer stays where it was.
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        START: begin
          link_start_q <= 1'b1;
          cnt_q        <= '0;
          state_q      <= WAIT;
        end
        WAIT: begin
          if (link_done) begin
            rsp_data_q <= link_rdata;
            rsp_err_q  <= ERR_OK;
            state_q    <= RESP;
          end else if (cnt_d == CNT_LAST) begin
            rsp_data_q <= '0;
            rsp_err_q  <= ERR_TIMEOUT;
            state_q    <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          rsp_valid_q <= gnt_oh;
          if (CHECK_INC && (rsp_err_q == ERR_OK) && (rsp_data_q != wdata_inc)) begin
            rsp_err_q <= ERR_MISMATCH;
          end
          ptr_q   <= (gnt_q == LAST_REQ) ? '0 : gnt_q + IW'(1);
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign link_start = link_start_q;
  assign link_wdata = link_wdata_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Directed bench for spi_xfer_scheduler: a table of complete transfers with
// hand-computed grants and responses, plus hand sequences for timeout,
// withdrawn request, stray link_done and reset in the middle of a transfer.
module tb_spi_xfer_scheduler;
  import spi_sched_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (long timeout) ----------------
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_data;
  logic [1:0]   rsp_err;
  logic         link_start;
  logic [31:0]  link_wdata;
  logic         link_done;
  logic [31:0]  link_rdata;
  logic         busy;
  state_e       dbg_state;

  spi_xfer_scheduler #(.NUM_REQ(4), .DATA_W(32), .TIMEOUT_CYC(64), .CHECK_INC(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .link_start (link_start),
    .link_wdata (link_wdata),
    .link_done  (link_done),
    .link_rdata (link_rdata),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- second DUT (TIMEOUT_CYC = 16) ----------------
  logic [3:0]   t_req_valid;
  logic [127:0] t_req_data;
  logic [3:0]   t_req_ready;
  logic [3:0]   t_rsp_valid;
  logic [31:0]  t_rsp_data;
  logic [1:0]   t_rsp_err;
  logic         t_link_start;
  logic [31:0]  t_link_wdata;
  logic         t_link_done;
  logic [31:0]  t_link_rdata;
  logic         t_busy;
  state_e       t_dbg_state;

  spi_xfer_scheduler #(.NUM_REQ(4), .DATA_W(32), .TIMEOUT_CYC(16), .CHECK_INC(1'b1)) dut_to (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (t_req_valid),
    .req_data   (t_req_data),
    .req_ready  (t_req_ready),
    .rsp_valid  (t_rsp_valid),
    .rsp_data   (t_rsp_data),
    .rsp_err    (t_rsp_err),
    .link_start (t_link_start),
    .link_wdata (t_link_wdata),
    .link_done  (t_link_done),
    .link_rdata (t_link_rdata),
    .busy       (t_busy),
    .dbg_state  (t_dbg_state)
  );

  // ---------------- scoreboard / counters ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Link-side monitor on the main DUT: overlap and one-hot violations.
  int n_starts    = 0;
  int overlap_err = 0;
  int onehot_err  = 0;
  bit outstanding = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 1'b0;
    end else begin
      if (link_start) begin
        if (outstanding) overlap_err++;
        outstanding = 1'b1;
        n_starts++;
      end
      if (rsp_valid != 4'b0000) outstanding = 1'b0;
      if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1) onehot_err++;
    end
  end

  // ---------------- transfer table ----------------
  typedef struct {
    logic [3:0]  mask;     // req_valid pattern presented
    logic [31:0] base;     // slice i carries base + i*0x100
    int          delay;    // cycles after link_start before link_done
    logic [31:0] rdata;    // word the link model returns
    int          exp_g;    // expected grant index
    logic [31:0] exp_w;    // expected link_wdata
    logic [1:0]  exp_err;  // expected rsp_err
  } xfer_t;

  xfer_t tbl[12];

  // Driver: called at a negedge with the DUT in IDLE; returns at the negedge
  // where the response pulse is visible (DUT back in IDLE).
  task automatic run_xfer(input xfer_t t, input int idx);
    string p;
    logic [3:0] oh;
    p  = $sformatf("x%0d", idx);
    oh = 4'b0001 << t.exp_g;
    exp_q.push_back(t.rdata);
    req_valid = t.mask;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = t.base + 32'(i) * 32'h100;
    @(negedge clk);
    check({p, "_busy_grant"}, 32'(busy), 32'd1);
    check({p, "_ready_early"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    check({p, "_ready"}, 32'(req_ready), 32'(oh));
    check({p, "_wdata"}, link_wdata, t.exp_w);
    req_valid = t.mask & ~oh;
    @(negedge clk);
    check({p, "_link_start"}, 32'(link_start), 32'd1);
    for (int c = 0; c < t.delay; c++) begin
      @(negedge clk);
      check({p, "_held_off"}, 32'(req_ready), 32'd0);
      check({p, "_start_once"}, 32'(link_start), 32'd0);
    end
    link_done  = 1'b1;
    link_rdata = t.rdata;
    @(negedge clk);
    link_done  = 1'b0;
    link_rdata = ~t.rdata;
    check({p, "_rsp_early"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check({p, "_rsp_valid"}, 32'(rsp_valid), 32'(oh));
    check({p, "_rsp_data"}, rsp_data, exp_q.pop_front());
    check({p, "_rsp_err"}, 32'(rsp_err), 32'(t.exp_err));
    check({p, "_busy_end"}, 32'(busy), 32'd0);
    req_valid = 4'b0000;
  endtask

  task automatic check_reset_values(input string p);
    check({p, "_req_ready"}, 32'(req_ready), 32'd0);
    check({p, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({p, "_link_start"}, 32'(link_start), 32'd0);
    check({p, "_busy"}, 32'(busy), 32'd0);
    check({p, "_rsp_data"}, rsp_data, 32'd0);
    check({p, "_link_wdata"}, link_wdata, 32'd0);
    check({p, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({p, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    xfer_t x;
    int k;

    //          mask     base          dly rdata         g  exp_w         err
    tbl[0]  = '{4'b0001, 32'h0000_0010, 40, 32'h0000_0011, 0, 32'h0000_0010, 2'b00};
    tbl[1]  = '{4'b1111, 32'h2000_0000,  0, 32'h2000_0101, 1, 32'h2000_0100, 2'b00};
    tbl[2]  = '{4'b1111, 32'h3000_0000,  1, 32'h3000_0201, 2, 32'h3000_0200, 2'b00};
    tbl[3]  = '{4'b1111, 32'h4000_0000,  2, 32'h4000_0301, 3, 32'h4000_0300, 2'b00};
    tbl[4]  = '{4'b1111, 32'h5000_0000,  3, 32'h5000_0001, 0, 32'h5000_0000, 2'b00};
    tbl[5]  = '{4'b0100, 32'h6000_0000,  0, 32'h6000_0201, 2, 32'h6000_0200, 2'b00};
    tbl[6]  = '{4'b0011, 32'h7000_0000,  5, 32'h7000_0001, 0, 32'h7000_0000, 2'b00};
    tbl[7]  = '{4'b1001, 32'h8000_0000,  2, 32'h8000_0301, 3, 32'h8000_0300, 2'b00};
    tbl[8]  = '{4'b0010, 32'h1234_5578,  4, 32'h1234_5678, 1, 32'h1234_5678, 2'b10};
    tbl[9]  = '{4'b0001, 32'hFFFF_FFFF,  1, 32'h0000_0000, 0, 32'hFFFF_FFFF, 2'b00};
    tbl[10] = '{4'b1111, 32'hA000_0000,  3, 32'hA000_0102, 1, 32'hA000_0100, 2'b10};
    tbl[11] = '{4'b1010, 32'hB000_0000,  0, 32'hB000_0301, 3, 32'hB000_0300, 2'b00};

    rst_n        = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    link_done    = 1'b0;
    link_rdata   = '0;
    t_req_valid  = '0;
    t_req_data   = '0;
    t_link_done  = 1'b0;
    t_link_rdata = '0;

    repeat (2) @(negedge clk);
    check_reset_values("rst_in");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("rst_out");

    // Table: single request, round-robin rotation, wrap, mismatch, inc wrap.
    for (int i = 0; i < 12; i++) run_xfer(tbl[i], i);

    // Withdrawn request: pointer is 0 after the last grant (3).
    req_valid = 4'b0100;
    req_data  = '0;
    @(negedge clk);
    check("wd_busy", 32'(busy), 32'd1);
    req_valid = 4'b0000;
    @(negedge clk);
    check("wd_no_ready", 32'(req_ready), 32'd0);
    check("wd_busy_low", 32'(busy), 32'd0);
    check("wd_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    check("wd_no_start", 32'(link_start), 32'd0);
    x = '{4'b1111, 32'hC000_0000, 2, 32'hC000_0001, 0, 32'hC000_0000, 2'b00};
    run_xfer(x, 12);

    // Stray link_done while IDLE.
    link_done  = 1'b1;
    link_rdata = 32'h0000_1234;
    @(negedge clk);
    link_done = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("stray_rsp", 32'(rsp_valid), 32'd0);
      check("stray_busy", 32'(busy), 32'd0);
    end

    // Timeout on the TIMEOUT_CYC=16 instance, then a normal transfer.
    t_req_valid = 4'b0010;
    t_req_data[32 +: 32] = 32'h0000_0055;
    @(negedge clk);
    @(negedge clk);
    check("to_ready", 32'(t_req_ready), 32'd2);
    check("to_wdata", t_link_wdata, 32'h0000_0055);
    t_req_valid = 4'b0000;
    @(negedge clk);
    check("to_start", 32'(t_link_start), 32'd1);
    k = 0;
    while (k < 40 && t_rsp_valid == 4'b0000) begin
      @(negedge clk);
      k++;
    end
    check("to_latency", 32'(k), 32'd16);
    check("to_rsp_valid", 32'(t_rsp_valid), 32'd2);
    check("to_rsp_err", 32'(t_rsp_err), 32'd1);
    check("to_rsp_data", t_rsp_data, 32'd0);
    t_req_valid = 4'b0001;
    t_req_data[0 +: 32] = 32'h0000_0077;
    @(negedge clk);
    @(negedge clk);
    check("to2_ready", 32'(t_req_ready), 32'd1);
    t_req_valid = 4'b0000;
    @(negedge clk);
    check("to2_start", 32'(t_link_start), 32'd1);
    t_link_done  = 1'b1;
    t_link_rdata = 32'h0000_0078;
    @(negedge clk);
    t_link_done = 1'b0;
    @(negedge clk);
    check("to2_rsp_valid", 32'(t_rsp_valid), 32'd1);
    check("to2_rsp_data", t_rsp_data, 32'h0000_0078);
    check("to2_rsp_err", 32'(t_rsp_err), 32'd0);
    check("to2_busy", 32'(t_busy), 32'd0);
    check("to2_state", 32'(t_dbg_state), 32'(IDLE));

    // Reset in the middle of WAIT; pointer is 1, only requester 3 asks.
    req_valid = 4'b1000;
    req_data  = '0;
    req_data[96 +: 32] = 32'hDEAD_0000;
    @(negedge clk);
    @(negedge clk);
    check("mr_ready", 32'(req_ready), 32'h8);
    check("mr_wdata", link_wdata, 32'hDEAD_0000);
    req_valid = 4'b0000;
    @(negedge clk);
    check("mr_start", 32'(link_start), 32'd1);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("mr_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    link_done  = 1'b1;
    link_rdata = 32'hDEAD_0001;
    @(negedge clk);
    link_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mr_late_rsp", 32'(rsp_valid), 32'd0);
      check("mr_late_busy", 32'(busy), 32'd0);
    end
    // Pointer went back to 0 with reset.
    x = '{4'b1111, 32'hE000_0000, 1, 32'hE000_0001, 0, 32'hE000_0000, 2'b00};
    run_xfer(x, 13);

    @(negedge clk);
    check("mon_overlap", 32'(overlap_err), 32'd0);
    check("mon_onehot", 32'(onehot_err), 32'd0);
    check("mon_starts", 32'(n_starts), 32'd15);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_xfer_scheduler.md
Name: spi_xfer_scheduler

Overview:
- Shares the single A-to-B SPI link (master/slave pair with echo-increment response) among NUM_REQ requesters.
- Arbitrates round-robin and launches one 32-bit transfer at a time.
- Waits for the phase-2 completion and returns B's response to the granted requester.
- Checks the increment contract and bounds each transfer with a timeout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, transfer word width.
- TIMEOUT_CYC, 4096, max clk cycles from link_start to link_done before abort (>=2).
- CHECK_INC, 1, when 1 flag a response not equal to wdata+1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester transfer request; held until req_ready.
- req_data  input  NUM_REQ*DATA_W  per-requester payload; slice i = bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse.
- rsp_valid  output  NUM_REQ  one-hot, one-cycle response pulse to the granted requester.
- rsp_data  output  DATA_W  response word; valid when any rsp_valid bit is set.
- rsp_err  output  2  00 ok, 01 timeout, 10 increment mismatch; qualified by rsp_valid.
- link_start  output  1  one-cycle pulse that launches a link transfer.
- link_wdata  output  DATA_W  word to send; held stable from link_start until the end of the transfer.
- link_done  input  1  phase-2 complete (B-to-A response captured).
- link_rdata  input  DATA_W  A's received word; sampled on link_done.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset:
  - state=IDLE; req_ready, rsp_valid, link_start, busy = 0.
  - rsp_data, link_wdata = 0; rsp_err = 00.
  - rr pointer = requester 0 has highest priority; timeout counter = 0.
- Synchronous state outputs; all outputs are registered.
- IDLE:
  - If req_valid is nonzero, pick g = first set bit at or after the pointer (wrapping), register g, go GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - If req_valid[g] is still 1: req_ready[g]=1 for this cycle, link_wdata <= req_data[g], go START.
  - If req_valid[g] has dropped: no accept, pointer unchanged, back to IDLE.
- START: link_start=1 for exactly one cycle, counter cleared, go WAIT.
- WAIT: counter increments each cycle.
  - link_done=1: capture link_rdata into rsp_data, go RESP.
  - Else if counter == TIMEOUT_CYC-1: rsp_data=0, err=01, go RESP.
  - link_done and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid[g]=1 for one cycle.
  - rsp_err = 10 if CHECK_INC and rsp_data != link_wdata+1 (mod 2^DATA_W); otherwise 00 (or 01 on timeout).
  - Pointer <= (g+1) mod NUM_REQ; go IDLE.
- Latency: req_valid seen in IDLE at cycle 0 -> req_ready cycle 1 -> link_start cycle 2 -> rsp_valid one cycle after link_done.
- Minimum turnaround for a new grant is 1 IDLE cycle after RESP.
- Increment wrap: wdata 0xFFFFFFFF expects 0x00000000 (no error).
- link_done outside WAIT is ignored; no state change, no response.
- New req_valid during non-IDLE states is held off (no req_ready) until the next IDLE.
- Reset mid-transfer: immediate return to reset values.
  - Any link activity is abandoned; no rsp_valid is issued for it.
- Only one transfer is ever outstanding; link_start never pulses outside START.

Decomposition:
- Package spi_sched_pkg:
  - state enum (IDLE, GRANT, START, WAIT, RESP).
  - rsp_err codes (ERR_OK, ERR_TIMEOUT, ERR_MISMATCH).
  - default DATA_W.
- Sub-module rr_arbiter: combinational first-set-at-or-after-pointer picker over NUM_REQ bits.
  - Outputs grant index and any-valid.
  - Pointer register stays in the scheduler.

Test Plan:
1. Single request: req_valid[0]=1, req_data[0]=0x00000010; link model returns 0x00000011 after 40 cycles -> req_ready[0] at cycle 1, link_start at cycle 2, rsp_valid[0] with rsp_data=0x00000011, rsp_err=00.
2. Round-robin: req_valid=4'b1111 held, each link responds correctly -> grant order 0,1,2,3,0; exactly one link_start per grant; never two transfers overlapping.
3. Timeout: TIMEOUT_CYC=16, link_done never asserts -> rsp_valid[g] exactly 16 cycles after link_start, rsp_err=01, rsp_data=0; next request then proceeds normally.
4. Mismatch and wrap: wdata 0x12345678, link returns 0x12345678 -> rsp_err=10; wdata 0xFFFFFFFF, link returns 0x00000000 -> rsp_err=00.
5. Request withdrawn: req_valid[2] pulses for 1 cycle in IDLE then drops -> no req_ready, no link_start, pointer unchanged, busy back to 0.
6. Reset mid-WAIT: assert rst_n=0 asynchronously 5 cycles after link_start -> all outputs at reset values immediately; a late link_done after reset release produces no rsp_valid.
